reg_op_sequencer: RTL and testbench
===================================

# reg_op_sequencer

Command sequencer that sits directly upstream of the 4-bit multi-function register (hold/clear/complement/load) and drives its `sel` and `I` inputs. It accepts operation commands through a valid/ready handshake, buffers them in a 4-entry FIFO, and replays each one on consecutive clock cycles with an optional repeat count. It also keeps a cycle-accurate prediction of the register contents, `a_pred`, for checking and for software readback.

## Interface
- `DEPTH`, 4: command FIFO entries; power of two, minimum 2.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  reset; asynchronous assert, active-low.
- `cmd_valid`  in  1  command present on `cmd_op`/`cmd_data`/`cmd_count`.
- `cmd_ready`  out  1  FIFO can accept a command; equals `!full`.
- `cmd_op`  in  2  operation: 00 hold, 01 clear, 10 complement, 11 load.
- `cmd_data`  in  4  load value; ignored for other ops.
- `cmd_count`  in  3  repeat count; the op is issued `cmd_count+1` cycles (1..8).
- `sel`  out  2  registered select to the downstream register.
- `I`  out  4  registered parallel data to the downstream register.
- `busy`  out  1  FIFO non-empty, or a command is still issuing.
- `a_pred`  out  4  predicted downstream register value after the most recent edge.

## Operation
- Transfer: a command is pushed when `cmd_valid && cmd_ready` at a rising edge.
  - `cmd_ready` depends only on FIFO occupancy, never on `cmd_valid`.
  - A full FIFO refuses a push even if a pop happens in the same cycle.
- States:
  - INIT: entered on reset. `sel` is held at 01 and `I` at 0, so the first edge after reset release clears the register. INIT then goes to IDLE unconditionally.
  - IDLE: `sel`=00, `I`=0. If the FIFO is non-empty, pop the head, load `sel`←op, `I`←(op==11 ? data : 0) and `rem`←count, then go to ISSUE.
  - ISSUE, with `rem`>0: decrement `rem` and keep `sel`/`I`.
  - ISSUE, with `rem`==0 and FIFO non-empty: pop the next command back-to-back, with no bubble.
  - ISSUE, with `rem`==0 and FIFO empty: `sel`←00, `I`←0, go to IDLE.
- Hold commands (op 00) with a count are legal. They produce `count+1` deliberate hold cycles.
- `a_pred` updates on every edge from the current `sel`/`I`:
  - 00: keep.
  - 01: 0.
  - 10: `~a_pred`.
  - 11: `I`.
- `busy` is asserted when state≠IDLE, or the FIFO is non-empty, or state==INIT.
- Count arithmetic is 3-bit unsigned. `rem` never wraps; the decrement happens only when `rem`>0.

## Timing
- Reset values:
  - `sel`=01, `I`=0, `a_pred`=0.
  - `busy`=1, `cmd_ready`=1.
  - FIFO empty, `rem`=0, state INIT.
- Reset mid-command flushes the FIFO and abandons the remaining repeats immediately, because reset is asynchronous.
- Latency, FIFO empty and IDLE:
  - Command accepted at edge k.
  - Popped at edge k+1, and `sel` shows the op after k+1.
  - The register performs the op at edge k+2.
  - `a_pred` reflects it after k+2.
- Throughput: one issued op per cycle. Back-to-back commands issue with no idle cycle between them.
- Push and pop in the same cycle are allowed when not full; occupancy is unchanged.
- Empty FIFO: no pop, and no bypass path exists.
- Full FIFO: `cmd_ready`=0 until a pop frees a slot. `cmd_ready` rises in the cycle after the pop edge.
- Pointer wrap: read and write pointers carry one extra bit. Full means the MSBs differ and the low bits are equal.

## Structure
- Shared package `reg_op_pkg` holds:
  - opcode constants `OP_HOLD`=2'b00, `OP_CLR`=2'b01, `OP_CMP`=2'b10, `OP_LOAD`=2'b11;
  - state encodings INIT/IDLE/ISSUE;
  - a packed command type {op[1:0], data[3:0], count[2:0]} (9 bits).
- Sub-module `cmd_fifo`: synchronous FIFO with parameter `DEPTH`.
  - Ports: push, pop, din, dout, full, empty.
  - Asynchronous active-low reset.
- The top level contains the FSM, the `rem` counter, the output registers and the `a_pred` model.

## Test plan
- Reset release with no commands: `sel`=01 for the first cycle, then 00. `a_pred`=0, and `busy` drops after one cycle.
- Load 4'hA (count 0), then complement (count 2), back-to-back:
  - `sel` sequence is 11,10,10,10,00.
  - `a_pred` sequence is A,5,A,5.
- With the downstream held off, push 5 commands with `cmd_valid` held high: 4 are accepted, then `cmd_ready`=0, and the 5th is accepted one cycle after the first pop.
- Load 4'h3, hold (count 7), clear: 8 cycles of `sel`=00 between 11 and 01. `a_pred` goes 3, then 0.
- Assert `rst_n`=0 mid-way through complement count 5:
  - outputs go immediately to `sel`=01, `I`=0, `a_pred`=0;
  - the FIFO is empty after reset, and queued commands are never issued.
- Simultaneous push and pop at occupancy 3: occupancy stays 3 and `cmd_ready` stays 1. Command order is preserved across pointer wrap over 20 random commands.

Source files
------------

// File: rtl/reg_op_sequencer_pkg.sv
// Shared definitions for the register-operation sequencer: opcodes,
// FSM state encoding and the packed command word carried through the FIFO.
package reg_op_pkg;

   localparam logic [1:0] OP_HOLD = 2'b00;
   localparam logic [1:0] OP_CLR  = 2'b01;
   localparam logic [1:0] OP_CMP  = 2'b10;
   localparam logic [1:0] OP_LOAD = 2'b11;

   typedef enum logic [1:0] {
      ST_INIT  = 2'd0,
      ST_IDLE  = 2'd1,
      ST_ISSUE = 2'd2
   } state_e;

   typedef struct packed {
      logic [1:0] op;
      logic [3:0] data;
      logic [2:0] count;
   } cmd_t;

endpackage

// File: rtl/reg_op_sequencer_cmd_fifo.sv
// Small synchronous command FIFO. Pointers carry one extra wrap bit so that
// full and empty can be told apart when the low bits match.
module cmd_fifo
   import reg_op_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic push,
   input  logic pop,
   input  cmd_t din,
   output cmd_t dout,
   output logic full,
   output logic empty
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0] wrPtr_q;
   logic [AW:0] rdPtr_q;
   cmd_t        mem_q [DEPTH];
   logic        doPush;
   logic        doPop;

   assign full   = (wrPtr_q[AW] != rdPtr_q[AW]) && (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
   assign empty  = (wrPtr_q == rdPtr_q);
   assign doPush = push && !full;
   assign doPop  = pop && !empty;
   assign dout   = mem_q[rdPtr_q[AW-1:0]];

   // Advance the read/write pointers; a full FIFO refuses a push even when a pop coincides.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
      end else begin
         if (doPush) wrPtr_q <= wrPtr_q + 1'b1;
         if (doPop)  rdPtr_q <= rdPtr_q + 1'b1;
      end
   end

   // Storage array; contents need no reset because the pointers gate every read.
   always_ff @(posedge clk) begin
      if (doPush) mem_q[wrPtr_q[AW-1:0]] <= din;
   end

endmodule

// File: rtl/reg_op_sequencer.sv
// Command sequencer feeding the 4-bit multi-function register. Buffers
// commands, replays each for count+1 cycles and tracks the predicted
// register contents in a_pred.
module reg_op_sequencer
   import reg_op_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [1:0] cmd_op,
   input  logic [3:0] cmd_data,
   input  logic [2:0] cmd_count,
   output logic [1:0] sel,
   output logic [3:0] I,
   output logic       busy,
   output logic [3:0] a_pred
);

   state_e     state_q, state_d;
   logic [1:0] sel_q, sel_d;
   logic [3:0] data_q, data_d;
   logic [2:0] rem_q, rem_d;
   logic [3:0] pred_q;
   logic       fifoPop;
   logic       fifoFull;
   logic       fifoEmpty;
   cmd_t       fifoDin;
   cmd_t       fifoHead;

   assign fifoDin = '{op: cmd_op, data: cmd_data, count: cmd_count};

   cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (cmd_valid),
      .pop   (fifoPop),
      .din   (fifoDin),
      .dout  (fifoHead),
      .full  (fifoFull),
      .empty (fifoEmpty)
   );

   assign cmd_ready = !fifoFull;
   assign busy      = (state_q != ST_IDLE) || !fifoEmpty;
   assign sel       = sel_q;
   assign I         = data_q;
   assign a_pred    = pred_q;

   // Next-state logic: INIT clears once, IDLE waits for work, ISSUE repeats then chains or retires.
   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      data_d  = data_q;
      rem_d   = rem_q;
      fifoPop = 1'b0;
      unique case (state_q)
         ST_INIT: begin
            sel_d   = OP_HOLD;
            data_d  = '0;
            state_d = ST_IDLE;
         end
         ST_IDLE: begin
            sel_d  = OP_HOLD;
            data_d = '0;
            if (!fifoEmpty) begin
               fifoPop = 1'b1;
               sel_d   = fifoHead.op;
               data_d  = (fifoHead.op == OP_LOAD) ? fifoHead.data : 4'h0;
               rem_d   = fifoHead.count;
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (rem_q != 3'd0) begin
               rem_d = rem_q - 3'd1;
            end else if (!fifoEmpty) begin
               fifoPop = 1'b1;
               sel_d   = fifoHead.op;
               data_d  = (fifoHead.op == OP_LOAD) ? fifoHead.data : 4'h0;
               rem_d   = fifoHead.count;
            end else begin
               sel_d   = OP_HOLD;
               data_d  = '0;
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_INIT;
            sel_d   = OP_CLR;
            data_d  = '0;
            rem_d   = '0;
         end
      endcase
   end

   // State, output and repeat-counter registers; reset forces a clear onto the register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_INIT;
         sel_q   <= OP_CLR;
         data_q  <= '0;
         rem_q   <= '0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         data_q  <= data_d;
         rem_q   <= rem_d;
      end
   end

   // Mirror what the downstream register does with the sel/I currently presented.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pred_q <= '0;
      end else begin
         unique case (sel_q)
            OP_HOLD: pred_q <= pred_q;
            OP_CLR:  pred_q <= '0;
            OP_CMP:  pred_q <= ~pred_q;
            OP_LOAD: pred_q <= data_q;
            default: pred_q <= pred_q;
         endcase
      end
   end

endmodule

// File: tb/tb_reg_op_sequencer.sv
// Self-checking bench for reg_op_sequencer: directed scenarios plus random
// traffic, all compared against a queue-based behavioural model.
module tb_reg_op_sequencer;

   localparam int DEPTH = 4;

   typedef struct packed {
      logic [1:0] op;
      logic [3:0] data;
      logic [2:0] count;
   } tbCmd_t;

   logic       clk;
   logic       rst_n;
   logic       cmdValid;
   logic       cmdReady;
   logic [1:0] cmdOp;
   logic [3:0] cmdData;
   logic [2:0] cmdCount;
   logic [1:0] selOut;
   logic [3:0] iOut;
   logic       busyOut;
   logic [3:0] predOut;

   int checkCount;
   int errorCount;

   // Behavioural model: pending command queue plus the command being issued.
   tbCmd_t     mQ[$];
   logic [1:0] mSel;
   logic [3:0] mI;
   logic [3:0] mPred;
   int         mLeft;
   bit         mActive;
   bit         mInit;

   reg_op_sequencer #(.DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd_valid (cmdValid),
      .cmd_ready (cmdReady),
      .cmd_op    (cmdOp),
      .cmd_data  (cmdData),
      .cmd_count (cmdCount),
      .sel       (selOut),
      .I         (iOut),
      .busy      (busyOut),
      .a_pred    (predOut)
   );

   // Free-running clock, 10 time units per period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic modelReset();
      mQ.delete();
      mSel    = 2'b01;
      mI      = 4'h0;
      mPred   = 4'h0;
      mLeft   = 0;
      mActive = 1'b0;
      mInit   = 1'b1;
   endtask

   task automatic modelEdge();
      bit     ready;
      tbCmd_t c;
      ready = (mQ.size() < DEPTH);
      case (mSel)
         2'b00: mPred = mPred;
         2'b01: mPred = 4'h0;
         2'b10: mPred = ~mPred;
         default: mPred = mI;
      endcase
      if (mInit) begin
         mInit = 1'b0; mSel = 2'b00; mI = 4'h0; mActive = 1'b0;
      end else if (mActive && mLeft > 0) begin
         mLeft--;
      end else if (mQ.size() > 0) begin
         c = mQ.pop_front();
         mSel = c.op;
         mI = (c.op == 2'b11) ? c.data : 4'h0;
         mLeft = int'(c.count);
         mActive = 1'b1;
      end else begin
         mSel = 2'b00; mI = 4'h0; mActive = 1'b0;
      end
      if (cmdValid && ready) mQ.push_back('{op: cmdOp, data: cmdData, count: cmdCount});
   endtask

   task automatic compareAll();
      checkOutput("sel", 8'(selOut), 8'(mSel));
      checkOutput("I", 8'(iOut), 8'(mI));
      checkOutput("a_pred", 8'(predOut), 8'(mPred));
      checkOutput("busy", 8'(busyOut), 8'(mInit || mActive || mQ.size() != 0));
      checkOutput("cmd_ready", 8'(cmdReady), 8'(mQ.size() < DEPTH));
   endtask

   // One clock: the model steps on the rising edge, outputs are compared on the falling edge.
   task automatic tick();
      @(posedge clk);
      modelEdge();
      @(negedge clk);
      compareAll();
   endtask

   task automatic applyStimulus(input logic valid, input logic [1:0] op, input logic [3:0] data, input logic [2:0] count);
      cmdValid = valid;
      cmdOp    = op;
      cmdData  = data;
      cmdCount = count;
      tick();
   endtask

   task automatic idleCycles(input int n);
      for (int k = 0; k < n; k++) applyStimulus(1'b0, 2'b00, 4'h0, 3'd0);
   endtask

   logic [1:0] expSel[5];
   logic [3:0] expPred[4];
   logic [1:0] selLog[$];
   logic [3:0] predLog[$];
   int         waits;
   int         zeros;
   int         idx;
   int         badIssue;

   initial begin
      checkCount = 0;
      errorCount = 0;
      rst_n    = 1'b0;
      cmdValid = 1'b0;
      cmdOp    = 2'b00;
      cmdData  = 4'h0;
      cmdCount = 3'd0;
      modelReset();

      // Reset values and release with no traffic.
      @(negedge clk);
      checkOutput("rst_sel", 8'(selOut), 8'h01);
      checkOutput("rst_busy", 8'(busyOut), 8'h01);
      checkOutput("rst_ready", 8'(cmdReady), 8'h01);
      rst_n = 1'b1;
      compareAll();
      idleCycles(1);
      checkOutput("busy_drop", 8'(busyOut), 8'h00);
      checkOutput("sel_after_init", 8'(selOut), 8'h00);
      idleCycles(2);

      // Load A then complement x3, back-to-back.
      expSel  = '{2'b11, 2'b10, 2'b10, 2'b10, 2'b00};
      expPred = '{4'hA, 4'h5, 4'hA, 4'h5};
      applyStimulus(1'b1, 2'b11, 4'hA, 3'd0);
      applyStimulus(1'b1, 2'b10, 4'h0, 3'd2);
      checkOutput("seqA_sel0", 8'(selOut), 8'(expSel[0]));
      for (int k = 1; k < 5; k++) begin
         applyStimulus(1'b0, 2'b00, 4'h0, 3'd0);
         checkOutput("seqA_sel", 8'(selOut), 8'(expSel[k]));
         checkOutput("seqA_pred", 8'(predOut), 8'(expPred[k-1]));
      end
      idleCycles(2);

      // Backpressure: long hold occupies the issuer while five commands queue up.
      applyStimulus(1'b1, 2'b00, 4'h0, 3'd7);
      for (int k = 0; k < 4; k++) applyStimulus(1'b1, 2'($urandom_range(0, 3)), 4'($urandom), 3'd0);
      checkOutput("full_ready", 8'(cmdReady), 8'h00);
      waits = 0;
      cmdValid = 1'b1; cmdOp = 2'b11; cmdData = 4'h9; cmdCount = 3'd0;
      while (waits < 20) begin
         if (cmdReady) begin
            tick();
            break;
         end
         tick();
         waits++;
      end
      checkOutput("fifth_wait", 8'(waits), 8'd5);
      idleCycles(16);

      // Load 3, hold x8, clear.
      selLog.delete();
      predLog.delete();
      applyStimulus(1'b1, 2'b11, 4'h3, 3'd0);
      selLog.push_back(selOut); predLog.push_back(predOut);
      applyStimulus(1'b1, 2'b00, 4'h0, 3'd7);
      selLog.push_back(selOut); predLog.push_back(predOut);
      applyStimulus(1'b1, 2'b01, 4'h0, 3'd0);
      selLog.push_back(selOut); predLog.push_back(predOut);
      for (int k = 0; k < 12; k++) begin
         applyStimulus(1'b0, 2'b00, 4'h0, 3'd0);
         selLog.push_back(selOut); predLog.push_back(predOut);
      end
      idx = 0;
      while (idx < selLog.size() && selLog[idx] != 2'b11) idx++;
      zeros = 0;
      idx++;
      while (idx < selLog.size() && selLog[idx] == 2'b00) begin
         zeros++;
         idx++;
      end
      checkOutput("hold_len", 8'(zeros), 8'd8);
      checkOutput("hold_then_clr", 8'(idx < selLog.size() ? selLog[idx] : 2'b00), 8'h01);
      checkOutput("pred_loaded", 8'(predLog[2]), 8'h03);
      checkOutput("pred_cleared", 8'(predLog[predLog.size()-1]), 8'h00);

      // Asynchronous reset in the middle of a long complement with commands queued.
      applyStimulus(1'b1, 2'b10, 4'h0, 3'd5);
      applyStimulus(1'b1, 2'b11, 4'hF, 3'd0);
      applyStimulus(1'b1, 2'b11, 4'h6, 3'd0);
      idleCycles(1);
      rst_n = 1'b0;
      #1;
      modelReset();
      checkOutput("arst_sel", 8'(selOut), 8'h01);
      checkOutput("arst_I", 8'(iOut), 8'h00);
      checkOutput("arst_pred", 8'(predOut), 8'h00);
      checkOutput("arst_ready", 8'(cmdReady), 8'h01);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      compareAll();
      badIssue = 0;
      for (int k = 0; k < 10; k++) begin
         applyStimulus(1'b0, 2'b00, 4'h0, 3'd0);
         if (selOut == 2'b11 || iOut != 4'h0) badIssue++;
      end
      checkOutput("flushed", 8'(badIssue), 8'd0);
      checkOutput("idle_after_flush", 8'(busyOut), 8'h00);

      // Random traffic: exercises push/pop overlap, full refusals and pointer wrap.
      for (int k = 0; k < 600; k++) begin
         applyStimulus(1'($urandom_range(0, 99) < 60), 2'($urandom_range(0, 3)), 4'($urandom),
                       ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 1)));
      end
      idleCycles(40);

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
